pipeline_sequencer: RTL and testbench
=====================================

Name: pipeline_sequencer

Overview:
Central stall/flush/halt scheduler for the 5-stage MIPS core. It takes the hazard request from the decode controller (bubble), the redirect from the branch/jump unit in EX, the halt-syscall flag from EX, and the data-memory busy signal. From these it drives the PC and per-stage pipeline-register enables and clears. It also owns the halt state machine and the cycle/stall/flush performance counters read by the display logic.

Parameters:
CNT_W, 32, width of each performance counter
DRAIN_CYCLES, 2, cycles spent in DRAIN so DM and WB retire before HALT (range 1..7)

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
bubble  in  1  ID hazard stall request (load-use or collision)
redirect  in  1  EX-resolved taken branch or jump
syscall_halt  in  1  halting syscall currently in EX
dm_busy  in  1  data memory not ready this cycle
resume  in  1  resume button level, already debounced
en_pc  out  1  PC write enable
en_ifid  out  1  IF/ID register enable
en_idex  out  1  ID/EX register enable
en_exdm  out  1  EX/DM register enable
en_dmwb  out  1  DM/WB register enable
clr_ifid  out  1  synchronous clear of IF/ID to NOP
clr_idex  out  1  synchronous clear of ID/EX to NOP
clr_exdm  out  1  synchronous clear of EX/DM to NOP
halted  out  1  high in HALT state
cnt_cycle  out  CNT_W  non-halted cycles
cnt_stall  out  CNT_W  stall cycles
cnt_flush  out  CNT_W  redirect flushes

Behaviour:
- All enable and clear outputs are combinational from state and inputs. halted, the counters, the state and resume_q are registered.
- Reset (rst_n=0, async): state=RUN, drain counter=0, resume_q=0, all counters=0. While in reset the combinational outputs decode as RUN with all inputs low: all en_*=1, all clr_*=0, halted=0. Reset mid-DRAIN or mid-HALT returns the block to RUN.
- States: RUN, DRAIN, HALT. 2-bit encoding defined in the shared package.
- RUN, evaluated in this priority order (first match wins):
  1. dm_busy=1: all en_*=0, no clears. syscall_halt and redirect are ignored this cycle; the stage holds, so they are re-presented.
  2. syscall_halt=1: en_pc=en_ifid=en_idex=0; en_exdm=en_dmwb=1; clr_exdm=1 so the syscall retires as a NOP. Next state DRAIN, drain counter loads DRAIN_CYCLES-1.
  3. redirect=1: all en=1, clr_ifid=clr_idex=1. This wins over a simultaneous bubble, because the stalled ID instruction is wrong-path.
  4. bubble=1: en_pc=en_ifid=0, clr_idex=1, the rest enabled.
  5. Otherwise: all en=1, no clears.
- DRAIN: en_pc=en_ifid=en_idex=0, en_exdm=en_dmwb=1, clr_exdm=1.
  - dm_busy=1 freezes everything, including the drain counter.
  - When the counter is 0 (and dm_busy=0), next state is HALT; otherwise the counter decrements.
- HALT: all en_*=0, no clears, halted=1 (registered, so it asserts the first cycle in HALT).
  - resume_q registers resume every cycle.
  - A rising edge (resume=1 and resume_q=0) moves the block to RUN. A resume held high from before HALT is ignored until it is released and pressed again.
- Timing: entry to HALT is exactly DRAIN_CYCLES+1 cycles after the cycle syscall_halt is accepted, plus any dm_busy cycles.
- Counters, all saturating at all-ones:
  - cnt_cycle increments every cycle the state is not HALT.
  - cnt_stall increments in RUN when case 1 or case 4 is taken.
  - cnt_flush increments in RUN when case 3 is taken.
- bubble, redirect and syscall_halt are don't-care in DRAIN and HALT.

Decomposition:
- Shared package (Core.vh): state encodings SEQ_ST_RUN/DRAIN/HALT, SEQ_ST_BIT, SEQ_CNT_W default.
- One natural sub-module, sat_counter (CNT_W wide, inc input, sync saturation, async active-low clear), instantiated three times.
- The edge detect and FSM stay in the top module.

Test Plan:
- Reset then idle inputs for 10 cycles: all en=1, clears=0, halted=0, cnt_cycle=10, cnt_stall=0, cnt_flush=0.
- bubble=1 for 1 cycle: that cycle en_pc=en_ifid=0 and clr_idex=1; next cycle all en=1; cnt_stall=1.
- bubble=1 and redirect=1 in the same cycle: en all 1, clr_ifid=clr_idex=1, cnt_flush=1, cnt_stall=0.
- syscall_halt=1 at cycle t, DRAIN_CYCLES=2: clr_exdm=1 during t..t+2; halted=1 from t+3; cnt_cycle freezes.
- HALT with resume held 1 since before halt: stays HALT. Drop resume, raise it: next cycle state=RUN, halted=0.
- dm_busy=1 for 3 cycles during DRAIN: all en=0 and the drain counter holds; HALT is reached 3 cycles later than without dm_busy.
- rst_n pulsed low mid-HALT: immediate RUN, halted=0, counters=0.

Source files
------------

// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the pipeline sequencer.
//   seq_state_t : RUN / DRAIN / HALT scheduler states (2-bit encoding)
//   SEQ_CNT_W   : default performance-counter width
package pipeline_sequencer_pkg;

    localparam int unsigned SEQ_ST_BIT = 2;
    localparam int unsigned SEQ_CNT_W  = 32;

    typedef enum logic [SEQ_ST_BIT-1:0] {
        SEQ_ST_RUN   = 2'd0,
        SEQ_ST_DRAIN = 2'd1,
        SEQ_ST_HALT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : clock
//   rst_n : asynchronous active-low clear
//   inc   : count enable for this cycle
//   cnt   : current value, sticks at all-ones
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush/halt scheduler for the 5-stage core.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bubble            : ID hazard stall request
//   redirect          : EX-resolved taken branch/jump
//   syscall_halt      : halting syscall in EX
//   dm_busy           : data memory not ready
//   resume            : debounced resume button level
//   en_*              : PC and pipeline-register enables (combinational)
//   clr_*             : synchronous NOP clears for IF/ID, ID/EX, EX/DM (combinational)
//   halted            : registered, high in HALT
//   cnt_cycle/stall/flush : saturating performance counters
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W        = SEQ_CNT_W,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bubble,
    input  logic             redirect,
    input  logic             syscall_halt,
    input  logic             dm_busy,
    input  logic             resume,
    output logic             en_pc,
    output logic             en_ifid,
    output logic             en_idex,
    output logic             en_exdm,
    output logic             en_dmwb,
    output logic             clr_ifid,
    output logic             clr_idex,
    output logic             clr_exdm,
    output logic             halted,
    output logic [CNT_W-1:0] cnt_cycle,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam logic [2:0] DRAIN_LOAD = 3'(DRAIN_CYCLES - 1);

    seq_state_t state;
    logic [2:0] drain_cnt;
    logic       resume_q;

    logic accept_halt;
    logic stall_evt;
    logic flush_evt;

    // Control decode; RUN cases are priority ordered.
    always_comb begin
        en_pc       = 1'b0;
        en_ifid     = 1'b0;
        en_idex     = 1'b0;
        en_exdm     = 1'b0;
        en_dmwb     = 1'b0;
        clr_ifid    = 1'b0;
        clr_idex    = 1'b0;
        clr_exdm    = 1'b0;
        accept_halt = 1'b0;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;
        case (state)
            SEQ_ST_RUN: begin
                if (dm_busy) begin
                    stall_evt = 1'b1;
                end else if (syscall_halt) begin
                    en_exdm     = 1'b1;
                    en_dmwb     = 1'b1;
                    clr_exdm    = 1'b1;
                    accept_halt = 1'b1;
                end else if (redirect) begin
                    // Wins over bubble: the stalled ID instruction is wrong-path.
                    en_pc     = 1'b1;
                    en_ifid   = 1'b1;
                    en_idex   = 1'b1;
                    en_exdm   = 1'b1;
                    en_dmwb   = 1'b1;
                    clr_ifid  = 1'b1;
                    clr_idex  = 1'b1;
                    flush_evt = 1'b1;
                end else if (bubble) begin
                    en_idex   = 1'b1;
                    en_exdm   = 1'b1;
                    en_dmwb   = 1'b1;
                    clr_idex  = 1'b1;
                    stall_evt = 1'b1;
                end else begin
                    en_pc   = 1'b1;
                    en_ifid = 1'b1;
                    en_idex = 1'b1;
                    en_exdm = 1'b1;
                    en_dmwb = 1'b1;
                end
            end
            SEQ_ST_DRAIN: begin
                if (!dm_busy) begin
                    en_exdm  = 1'b1;
                    en_dmwb  = 1'b1;
                    clr_exdm = 1'b1;
                end
            end
            SEQ_ST_HALT: begin
            end
            default: begin
                en_pc   = 1'b1;
                en_ifid = 1'b1;
                en_idex = 1'b1;
                en_exdm = 1'b1;
                en_dmwb = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEQ_ST_RUN;
            drain_cnt <= '0;
            resume_q  <= 1'b0;
            halted    <= 1'b0;
        end else begin
            // Tracked in every state so a resume held from before HALT is not an edge.
            resume_q <= resume;
            case (state)
                SEQ_ST_RUN: begin
                    if (accept_halt) begin
                        state     <= SEQ_ST_DRAIN;
                        drain_cnt <= DRAIN_LOAD;
                    end
                end
                SEQ_ST_DRAIN: begin
                    if (!dm_busy) begin
                        if (drain_cnt == '0) begin
                            state  <= SEQ_ST_HALT;
                            halted <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                SEQ_ST_HALT: begin
                    if (resume && !resume_q) begin
                        state  <= SEQ_ST_RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= SEQ_ST_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_cycle (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (state != SEQ_ST_HALT),
        .cnt   (cnt_cycle)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_evt),
        .cnt   (cnt_stall)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_evt),
        .cnt   (cnt_flush)
    );

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios followed by
// randomized traffic, all checked against a behavioural model.
module tb_pipeline_sequencer;

    localparam int unsigned CW    = 8;
    localparam int unsigned DRAIN = 2;
    localparam int          SAT   = 255;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bubble, redirect, syscall_halt, dm_busy, resume;
    logic          en_pc, en_ifid, en_idex, en_exdm, en_dmwb;
    logic          clr_ifid, clr_idex, clr_exdm, halted;
    logic [CW-1:0] cnt_cycle, cnt_stall, cnt_flush;
    logic [7:0]    ctrl_now;

    always #5 clk = ~clk;

    assign ctrl_now = {en_pc, en_ifid, en_idex, en_exdm, en_dmwb, clr_ifid, clr_idex, clr_exdm};

    pipeline_sequencer #(.CNT_W(CW), .DRAIN_CYCLES(DRAIN)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bubble       (bubble),
        .redirect     (redirect),
        .syscall_halt (syscall_halt),
        .dm_busy      (dm_busy),
        .resume       (resume),
        .en_pc        (en_pc),
        .en_ifid      (en_ifid),
        .en_idex      (en_idex),
        .en_exdm      (en_exdm),
        .en_dmwb      (en_dmwb),
        .clr_ifid     (clr_ifid),
        .clr_idex     (clr_idex),
        .clr_exdm     (clr_exdm),
        .halted       (halted),
        .cnt_cycle    (cnt_cycle),
        .cnt_stall    (cnt_stall),
        .cnt_flush    (cnt_flush)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model: "halt mode", "draining with N cycles left", or running.
    bit m_halt, m_drain, m_res_prev;
    int m_left, m_cyc, m_stall, m_flush;

    function automatic int sat_inc(input int v);
        return (v < SAT) ? v + 1 : v;
    endfunction

    // {en_pc,en_ifid,en_idex,en_exdm,en_dmwb,clr_ifid,clr_idex,clr_exdm}
    function automatic logic [7:0] exp_ctrl(input logic b, input logic r, input logic s, input logic d);
        if (m_halt) return 8'b00000_000;
        if (m_drain) return d ? 8'b00000_000 : 8'b00011_001;
        if (d) return 8'b00000_000;
        if (s) return 8'b00011_001;
        if (r) return 8'b11111_110;
        if (b) return 8'b00111_010;
        return 8'b11111_000;
    endfunction

    task automatic model_reset();
        m_halt = 0; m_drain = 0; m_res_prev = 0;
        m_left = 0; m_cyc = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic model_step(input logic b, input logic r, input logic s, input logic d, input logic res);
        bit run;
        run = !m_halt && !m_drain;
        if (!m_halt) m_cyc = sat_inc(m_cyc);
        if (run && (d || (b && !s && !r))) m_stall = sat_inc(m_stall);
        if (run && !d && !s && r) m_flush = sat_inc(m_flush);
        if (m_halt) begin
            if (res && !m_res_prev) m_halt = 0;
        end else if (m_drain) begin
            if (!d) begin
                if (m_left == 0) begin
                    m_drain = 0;
                    m_halt  = 1;
                end else begin
                    m_left--;
                end
            end
        end else if (!d && s) begin
            m_drain = 1;
            m_left  = DRAIN - 1;
        end
        m_res_prev = res;
    endtask

    // Called at posedge+1: drive, check mid-cycle, then advance one edge.
    task automatic cycle(input logic b, input logic r, input logic s, input logic d, input logic res);
        bubble = b; redirect = r; syscall_halt = s; dm_busy = d; resume = res;
        #3;
        check("ctrl", ctrl_now, exp_ctrl(b, r, s, d));
        check("halted", halted, m_halt);
        check("cnt_cycle", cnt_cycle, m_cyc);
        check("cnt_stall", cnt_stall, m_stall);
        check("cnt_flush", cnt_flush, m_flush);
        @(posedge clk);
        model_step(b, r, s, d, res);
        #1;
    endtask

    task automatic do_reset();
        bubble = 0; redirect = 0; syscall_halt = 0; dm_busy = 0; resume = 0;
        rst_n = 0;
        #2;
        model_reset();
        check("rst_ctrl", ctrl_now, 8'b11111_000);
        check("rst_halted", halted, 1'b0);
        check("rst_cnt_cycle", cnt_cycle, 0);
        check("rst_cnt_stall", cnt_stall, 0);
        check("rst_cnt_flush", cnt_flush, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        logic b, r, s, d, res;
        rst_n = 0;
        bubble = 0; redirect = 0; syscall_halt = 0; dm_busy = 0; resume = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Idle run
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0);
        check("idle_cnt_cycle", cnt_cycle, 10);

        // Single bubble, then bubble with redirect
        cycle(1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("bubble_cnt_stall", cnt_stall, 1);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("redir_cnt_flush", cnt_flush, 1);
        check("redir_cnt_stall", cnt_stall, 1);

        // Halt with resume held since before the halt
        cycle(0, 0, 1, 0, 1);
        cycle(1, 1, 1, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check("halt_latency", halted, 1'b1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);
        check("held_resume_ignored", halted, 1'b1);
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check("resume_edge", halted, 1'b0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1);

        // Drain stretched by three dm_busy cycles
        cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 0);
        check("busy_drain_not_yet", halted, 1'b0);
        cycle(0, 0, 0, 0, 0);
        check("busy_drain_halted", halted, 1'b1);
        cycle(0, 0, 0, 0, 0);

        // Reset while halted
        do_reset();

        // Random traffic; long enough to saturate cnt_cycle
        res = 0;
        for (int i = 0; i < 600; i++) begin
            b = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 5) == 0);
            s = ($urandom_range(0, 11) == 0);
            d = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 2) == 0) res = ~res;
            cycle(b, r, s, d, res);
        end
        check("cnt_cycle_saturated", cnt_cycle, SAT);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
